mips_run_ctrl: RTL

//  Run/step/breakpoint sequencer for the single-cycle MIPS core. Sits between the board inputs
//  (pb, run switch) and mips_top, and drives the processor clock enable cpu_en.

---
 rtl/mips_run_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mips_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-cycle MIPS core.
// Turns a bouncy pushbutton into run/step commands and gates the core clock enable.
module mips_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             pb,
    input  logic             run_sw,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    input  logic [CNT_W-1:0] max_cycles,
    output logic             cpu_en,
    output logic             halted,
    output logic             bp_hit,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    state_t          cur_state;
    logic            sync1;
    logic            sync2;
    logic            db_level;
    logic            db_prev;
    logic [DB_W-1:0] db_cnt;
    logic            bp_skip;
    logic            pb_pulse;
    logic            limit_hit;
    logic            bp_match;

    // The debounced level only flips after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= pb;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 != db_level) begin
                if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign pb_pulse  = db_level & ~db_prev;
    assign limit_hit = (max_cycles != '0) && (cycle_count == max_cycles);
    assign bp_match  = bp_en && (pc == bp_addr) && !bp_skip;

    // Enable is combinational so a breakpoint blocks the matching instruction in the same cycle.
    always_comb begin
        cpu_en = 1'b0;
        unique case (cur_state)
            IDLE: cpu_en = 1'b0;
            RUN:  cpu_en = !bp_match && !limit_hit && run_sw;
            STEP: cpu_en = !limit_hit;
            HALT: cpu_en = 1'b0;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            bp_hit      <= 1'b0;
            timeout     <= 1'b0;
            bp_skip     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (cpu_en && (cycle_count != '1)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            unique case (cur_state)
                IDLE: begin
                    if (pb_pulse) begin
                        cur_state <= run_sw ? RUN : STEP;
                    end
                end
                RUN: begin
                    bp_skip <= 1'b0;
                    if (bp_match || limit_hit) begin
                        cur_state <= HALT;
                        if (bp_match) begin
                            bp_hit <= 1'b1;
                        end
                        if (limit_hit) begin
                            timeout <= 1'b1;
                        end
                    end else if (!run_sw) begin
                        cur_state <= IDLE;
                    end
                end
                STEP: begin
                    if (limit_hit) begin
                        cur_state <= HALT;
                        timeout   <= 1'b1;
                    end else begin
                        cur_state <= IDLE;
                    end
                end
                HALT: begin
                    // A watchdog halt is terminal; only reset leaves it.
                    if (!timeout && pb_pulse) begin
                        bp_hit <= 1'b0;
                        if (run_sw) begin
                            cur_state <= RUN;
                            bp_skip   <= 1'b1;
                        end else begin
                            cur_state <= STEP;
                        end
                    end
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

    assign halted = (cur_state == HALT);
    assign state  = cur_state;

endmodule
